// File: rtl/bcd_mod_counter_pkg.sv
// clk_bcd_pkg -- BCD digit/pair types and conversion helpers shared by the timekeeping counters.
// Revision: 1.0
`default_nettype none

package clk_bcd_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd2_t;

  localparam bcd_digit_t BCD_DIGIT_MAX = 4'd9;

  function automatic int bcd2_to_dec(input bcd2_t v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bcd2_t dec_to_bcd2(input int d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  function automatic logic bcd2_digits_ok(input bcd2_t v);
    return (v[7:4] <= BCD_DIGIT_MAX) && (v[3:0] <= BCD_DIGIT_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mod_counter_if.sv
// bcd_mod_counter_if -- control/status bundle of one BCD modulo counter stage (ALM_VAL with BCD_MOD_CNT_ALARM_EN).
// Revision: 1.0
`default_nettype none

interface bcd_mod_counter_if;
  import clk_bcd_pkg::*;

  logic  EN;
  logic  DN;
  logic  LD;
  bcd2_t LD_VAL;
  bcd2_t CNT;
  logic  TC;
  logic  LD_ERR;
  logic  ALM;
`ifdef BCD_MOD_CNT_ALARM_EN
  bcd2_t ALM_VAL;

  modport master (output EN, DN, LD, LD_VAL, ALM_VAL, input CNT, TC, LD_ERR, ALM);
  modport slave  (input EN, DN, LD, LD_VAL, ALM_VAL, output CNT, TC, LD_ERR, ALM);
`else
  modport master (output EN, DN, LD, LD_VAL, input CNT, TC, LD_ERR, ALM);
  modport slave  (input EN, DN, LD, LD_VAL, output CNT, TC, LD_ERR, ALM);
`endif

endinterface

`default_nettype wire

// File: rtl/bcd_mod_counter_digit_step.sv
// bcd_digit_step -- single BCD digit increment/decrement with 9<->0 wrap and carry/borrow flag.
// Revision: 1.0
`default_nettype none

module bcd_digit_step
  import clk_bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       dn_i,
  output bcd_digit_t digit_o,
  output logic       wrap_o
);

  always_comb begin
    digit_o = digit_i;
    wrap_o  = 1'b0;
    if (dn_i) begin
      if (digit_i == 4'd0) begin
        digit_o = BCD_DIGIT_MAX;
        wrap_o  = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end else begin
      if (digit_i >= BCD_DIGIT_MAX) begin
        digit_o = 4'd0;
        wrap_o  = 1'b1;
      end else begin
        digit_o = digit_i + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter -- two-digit BCD up/down modulo counter with validated load and chainable TC.
// Optional alarm match pulse enabled by macro BCD_MOD_CNT_ALARM_EN. Revision: 1.0
`default_nettype none

module bcd_mod_counter
  import clk_bcd_pkg::*;
#(
  parameter int MODULUS   = 24,
  parameter int MIN_VALUE = 0,
  parameter int RST_VALUE = 0
) (
  input  logic             CP,
  input  logic             nCR,
  bcd_mod_counter_if.slave bus
);

  localparam int    MAX_VALUE = MIN_VALUE + MODULUS - 1;
  localparam bcd2_t MIN_BCD   = dec_to_bcd2(MIN_VALUE);
  localparam bcd2_t MAX_BCD   = dec_to_bcd2(MAX_VALUE);
  localparam bcd2_t RST_BCD   = dec_to_bcd2(RST_VALUE);

  bcd2_t      cnt_q, cnt_d;
  logic       ld_err_q, ld_err_d;
  logic       count_en, at_limit, cnt_legal, ld_legal;
  logic       units_wrap, tens_wrap;
  bcd_digit_t units_nxt, tens_step;

  function automatic logic in_range(input bcd2_t v);
    int d;
    d = bcd2_to_dec(v);
    return bcd2_digits_ok(v) && (d >= MIN_VALUE) && (d <= MAX_VALUE);
  endfunction

  assign cnt_legal = in_range(cnt_q);
  assign ld_legal  = in_range(bus.LD_VAL);
  assign count_en  = bus.EN & ~bus.LD;
  assign at_limit  = bus.DN ? (cnt_q == MIN_BCD) : (cnt_q == MAX_BCD);

  bcd_digit_step u_units (
    .digit_i (cnt_q[3:0]),
    .dn_i    (bus.DN),
    .digit_o (units_nxt),
    .wrap_o  (units_wrap)
  );

  bcd_digit_step u_tens (
    .digit_i (cnt_q[7:4]),
    .dn_i    (bus.DN),
    .digit_o (tens_step),
    .wrap_o  (tens_wrap)
  );

  // Tens only moves on a units carry/borrow; a tens wrap (99/00) is a modulo wrap too.
  always_comb begin
    cnt_d    = cnt_q;
    ld_err_d = 1'b0;
    if (bus.LD) begin
      if (ld_legal) begin
        cnt_d = bus.LD_VAL;
      end else begin
        ld_err_d = 1'b1;
      end
    end else if (bus.EN) begin
      if (!cnt_legal) begin
        cnt_d = MIN_BCD;
      end else if (at_limit || (units_wrap && tens_wrap)) begin
        cnt_d = bus.DN ? MAX_BCD : MIN_BCD;
      end else begin
        cnt_d = {(units_wrap ? tens_step : cnt_q[7:4]), units_nxt};
      end
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      cnt_q    <= RST_BCD;
      ld_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ld_err_q <= ld_err_d;
    end
  end

  // Gated by nCR so a stage held in reset never enables the next one.
  assign bus.TC     = nCR & count_en & cnt_legal & at_limit;
  assign bus.CNT    = cnt_q;
  assign bus.LD_ERR = ld_err_q;

`ifdef BCD_MOD_CNT_ALARM_EN
  logic alm_q, alm_d;

  always_comb begin
    alm_d = count_en && (cnt_d == bus.ALM_VAL) && (cnt_d != cnt_q);
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      alm_q <= 1'b0;
    end else begin
      alm_q <= alm_d;
    end
  end

  assign bus.ALM = alm_q;
`else
  assign bus.ALM = 1'b0;
`endif

endmodule

`default_nettype wire
